// File: rtl/ps2_note_decoder.sv
// PS/2 keyboard receiver with make/break decoding into a 14-bit note divider word.
// origin = 0 means no note is held.
module ps2_note_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [13:0] origin,
  output logic        key_valid,
  output logic [7:0]  scan_code,
  output logic        scan_strobe,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]  r_clk_sync;
  logic [1:0]  r_data_sync;
  logic        r_filt;
  logic        r_filt_d;
  logic [FW-1:0] r_fcnt;
  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic [TW-1:0] r_tcnt;
  logic [7:0]  r_scan_code;
  logic        r_scan_strobe;
  logic        r_frame_err;
  logic [13:0] r_origin;
  logic        r_key_valid;
  logic        r_break;

  logic        w_fall;
  logic        w_data;
  logic [13:0] w_lut;
  logic [13:0] w_origin_next;
  logic        w_break_next;

  function automatic logic [13:0] note_lut(input logic [7:0] code);
    case (code)
      8'h15: note_lut = 14'd6826;   8'h1D: note_lut = 14'd7871;
      8'h24: note_lut = 14'd8798;   8'h2D: note_lut = 14'd9224;
      8'h2C: note_lut = 14'd10005;  8'h35: note_lut = 14'd10701;
      8'h3C: note_lut = 14'd11321;  8'h1C: note_lut = 14'd11606;
      8'h1B: note_lut = 14'd12126;  8'h23: note_lut = 14'd12591;
      8'h2B: note_lut = 14'd12804;  8'h34: note_lut = 14'd13194;
      8'h33: note_lut = 14'd13524;  8'h3B: note_lut = 14'd13852;
      8'h1A: note_lut = 14'd13994;  8'h22: note_lut = 14'd14255;
      8'h21: note_lut = 14'd14487;  8'h2A: note_lut = 14'd14593;
      8'h32: note_lut = 14'd14789;  8'h31: note_lut = 14'd14963;
      8'h3A: note_lut = 14'd15117;
      default: note_lut = 14'd0;
    endcase
  endfunction

  // Synchronizers idle high so reset does not fabricate a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt      <= 1'b1;
      r_filt_d    <= 1'b1;
      r_fcnt      <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_filt_d    <= r_filt;
      if (r_clk_sync[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_sync[1];
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_data = r_data_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_tcnt        <= '0;
      r_scan_code   <= '0;
      r_scan_strobe <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_scan_strobe <= 1'b0;
      r_frame_err   <= 1'b0;
      if (r_state == S_IDLE) begin
        r_tcnt <= '0;
        if (w_fall && !w_data) begin
          r_state  <= S_DATA;
          r_bitcnt <= '0;
        end
      end else if (w_fall) begin
        r_tcnt <= '0;
        case (r_state)
          S_DATA: begin
            r_shift  <= {w_data, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_data;
            r_state <= S_STOP;
          end
          default: begin
            // Odd parity: the nine bits together must carry an odd number of ones.
            if (w_data && (^{r_shift, r_par})) begin
              r_scan_code   <= r_shift;
              r_scan_strobe <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_tcnt      <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign w_lut = note_lut(r_scan_code);

  always_comb begin
    w_origin_next = r_origin;
    w_break_next  = r_break;
    if (r_scan_strobe) begin
      if (r_scan_code == 8'hF0) begin
        w_break_next = 1'b1;
      end else if (r_scan_code == 8'hE0) begin
        w_break_next = r_break;
      end else if (r_break) begin
        w_break_next = 1'b0;
        if (w_lut == r_origin) w_origin_next = 14'd0;
      end else if (w_lut != 14'd0) begin
        w_origin_next = w_lut;
      end
    end else if (r_frame_err) begin
      w_break_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_origin    <= '0;
      r_key_valid <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_origin    <= w_origin_next;
      r_key_valid <= (w_origin_next != 14'd0);
      r_break     <= w_break_next;
    end
  end

  assign origin      = r_origin;
  assign key_valid   = r_key_valid;
  assign scan_code   = r_scan_code;
  assign scan_strobe = r_scan_strobe;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: bit-level PS/2 frames with hand-computed notes.
module tb_ps2_note_decoder;

  localparam int TOUT = 1000;
  localparam int HP   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [13:0] origin;
  logic        key_valid;
  logic [7:0]  scan_code;
  logic        scan_strobe;
  logic        frame_err;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_err = 0;
  int s0, e0;

  ps2_note_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .origin(origin), .key_valid(key_valid), .scan_code(scan_code),
    .scan_strobe(scan_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (scan_strobe) n_strobe++;
      if (frame_err) n_err++;
    end
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit; gw>0 inserts a gw-cycle glitch in both the high and low phase.
  task automatic ps2_bit(input logic d, input int gw);
    ps2_data = d;
    if (gw > 0) begin
      wait_cyc(4); ps2_clk = 1'b0; wait_cyc(gw); ps2_clk = 1'b1; wait_cyc(HP/2 - 4 - gw);
      ps2_clk = 1'b0; wait_cyc(8); ps2_clk = 1'b1; wait_cyc(gw); ps2_clk = 1'b0; wait_cyc(HP - 8 - gw);
    end else begin
      wait_cyc(HP/2); ps2_clk = 1'b0; wait_cyc(HP);
    end
    ps2_clk = 1'b1;
    wait_cyc(HP/2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stopb,
                            input logic glitch);
    $display("tx frame 0x%02h par_flip=%0b stop=%0b glitch=%0b", b, par_flip, stopb, glitch);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch ? ((i % 3 == 0) ? 3 : 1) : 0);
    ps2_bit((~^b) ^ par_flip, 0);
    ps2_bit(stopb, 0);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    chk_val("rst_origin", origin, 0);
    chk_val("rst_key_valid", key_valid, 0);
    chk_val("rst_scan_code", scan_code, 0);
    chk_val("rst_strobe", scan_strobe, 0);
    chk_val("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    wait_cyc(10);

    // Single make of Q
    s0 = n_strobe;
    key(8'h15);
    chk_val("q_strobe_cnt", n_strobe - s0, 1);
    chk_val("q_scan_code", scan_code, 8'h15);
    chk_val("q_origin", origin, 6826);
    chk_val("q_key_valid", key_valid, 1);

    // Break prefix alone keeps the note, then the release clears it
    key(8'hF0);
    chk_val("f0_scan_code", scan_code, 8'hF0);
    chk_val("f0_origin_held", origin, 6826);
    key(8'h15);
    chk_val("q_break_origin", origin, 0);
    chk_val("q_break_kv", key_valid, 0);

    // Last key wins; releasing an older key does nothing
    key(8'h15);
    key(8'h1C);
    chk_val("a_over_q", origin, 11606);
    key(8'hF0); key(8'h15);
    chk_val("q_rel_ignored", origin, 11606);
    chk_val("q_rel_kv", key_valid, 1);
    key(8'hF0); key(8'h1C);
    chk_val("a_rel_origin", origin, 0);
    chk_val("a_rel_kv", key_valid, 0);

    // Parity and stop errors
    key(8'h15);
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk_val("par_err_cnt", n_err - e0, 1);
    chk_val("par_strobe_cnt", n_strobe - s0, 0);
    chk_val("par_origin", origin, 6826);
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk_val("stop_err_cnt", n_err - e0, 1);
    chk_val("stop_strobe_cnt", n_strobe - s0, 0);
    chk_val("stop_origin", origin, 6826);

    // A frame error cancels a pending break, so 1C becomes a make
    key(8'hF0);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    key(8'h1C);
    chk_val("err_clears_break", origin, 11606);

    // E0 prefix is transparent to a pending break
    key(8'hF0); key(8'hE0); key(8'h1C);
    chk_val("e0_break_origin", origin, 0);

    // Unmapped make leaves origin alone
    key(8'h2C);
    key(8'h76);
    chk_val("unmapped_scan", scan_code, 8'h76);
    chk_val("unmapped_origin", origin, 10005);

    // Timeout after four data bits
    $display("tx partial frame, 4 data bits then clock stops");
    e0 = n_err;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    ps2_data = 1'b1;
    wait_cyc(TOUT - 100);
    chk_val("tout_not_early", n_err - e0, 0);
    wait_cyc(200);
    chk_val("tout_err_cnt", n_err - e0, 1);
    chk_val("tout_origin", origin, 10005);
    key(8'h3A);
    chk_val("after_tout_origin", origin, 15117);
    chk_val("after_tout_scan", scan_code, 8'h3A);

    // Short ps2_clk glitches must be filtered out
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h2D, 1'b0, 1'b1, 1'b1);
    chk_val("glitch_strobe_cnt", n_strobe - s0, 1);
    chk_val("glitch_err_cnt", n_err - e0, 0);
    chk_val("glitch_origin", origin, 9224);

    // Reset in the middle of a frame
    $display("tx partial frame, reset after 3 data bits");
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0);
    ps2_data = 1'b1;
    reset = 1'b1;
    wait_cyc(3);
    chk_val("midrst_origin", origin, 0);
    chk_val("midrst_kv", key_valid, 0);
    chk_val("midrst_scan", scan_code, 0);
    reset = 1'b0;
    wait_cyc(10);
    s0 = n_strobe;
    key(8'h1D);
    chk_val("post_rst_strobe_cnt", n_strobe - s0, 1);
    chk_val("post_rst_scan", scan_code, 8'h1D);
    chk_val("post_rst_origin", origin, 7871);
    chk_val("post_rst_kv", key_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
